// File: rtl/word_arbmux_if.sv
// word_arbmux_if: request/accept and output bus bundle for word_arbmux.
//   i_valid/i_data/o_ready : per-channel producer side (channel c at [c*WIDTH +: WIDTH])
//   o_valid/o_data/o_sel/i_ready : single consumer side
//   slave modport is the mux view, master modport is the producer/consumer view.
interface word_arbmux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS-1:0]       i_valid;
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [CHANNELS-1:0]       o_ready;
  logic                      o_valid;
  logic [WIDTH-1:0]          o_data;
  logic [SEL_W-1:0]          o_sel;
  logic                      i_ready;
  modport slave  (input i_valid, i_data, i_ready, output o_ready, o_valid, o_data, o_sel);
  modport master (output i_valid, i_data, i_ready, input o_ready, o_valid, o_data, o_sel);
endinterface

// File: rtl/word_arbmux.sv
// word_arbmux: registered N-to-1 word mux with per-channel valid/ready and built-in arbitration.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   bus     : word_arbmux_if.slave (i_valid, i_data, o_ready, o_valid, o_data, o_sel, i_ready)
//   WORD_ARBMUX_RR_EN defined selects round-robin arbitration; undefined gives fixed
//   priority (lowest index wins) and no pointer register.
module word_arbmux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic           i_clk,
  input logic           i_rst_n,
  word_arbmux_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           state;
  logic             load;
  logic             gany;
  logic [SEL_W-1:0] gsel;
  logic [SEL_W-1:0] k;
`ifdef WORD_ARBMUX_RR_EN
  logic [SEL_W-1:0] ptr;
`endif
  assign load = (state == EMPTY) || bus.i_ready;
  // Walk from the highest search offset down so the closest requester wins.
  always_comb begin
    gany = 1'b0;
    gsel = '0;
    k    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
`ifdef WORD_ARBMUX_RR_EN
      k = SEL_W'((int'(ptr) + i) % CHANNELS);
`else
      k = SEL_W'(i);
`endif
      if (bus.i_valid[k]) begin
        gany = 1'b1;
        gsel = k;
      end
    end
  end
  assign bus.o_ready = (load && gany) ? (CHANNELS'(1) << gsel) : '0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= EMPTY;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_sel   <= '0;
`ifdef WORD_ARBMUX_RR_EN
      ptr         <= '0;
`endif
    end else if (load) begin
      if (gany) begin
        state       <= FULL;
        bus.o_valid <= 1'b1;
        bus.o_data  <= bus.i_data[int'(gsel)*WIDTH +: WIDTH];
        bus.o_sel   <= gsel;
`ifdef WORD_ARBMUX_RR_EN
        ptr         <= (gsel == SEL_W'(CHANNELS - 1)) ? '0 : gsel + 1'b1;
`endif
      end else begin
        state       <= EMPTY;
        bus.o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_word_arbmux.sv
// tb_word_arbmux: directed and randomized checks of word_arbmux against a queue-free reference model.
module tb_word_arbmux;
  localparam int W = 16;
  localparam int C = 4;
  localparam int S = 2;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  word_arbmux_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus ();
  word_arbmux #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );
  always #5 i_clk = ~i_clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_sel = 0;
  int           m_ptr = 0;
  // Reference arbitration: the requester nearest at or after m_ptr (mod C).
  // Fixed priority is the same rule with the pointer pinned at 0.
  function automatic int pick();
    int best = -1;
    int bd = C;
    for (int c = 0; c < C; c++)
      if (bus.i_valid[c]) begin
        int d = (c - m_ptr + C) % C;
        if (d < bd) begin
          bd = d;
          best = c;
        end
      end
    return best;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask
  // Check at the falling edge, then advance the model across the rising edge.
  task automatic step(string tag);
    int g;
    logic ld;
    logic [C-1:0] er;
    @(negedge i_clk);
    g  = pick();
    ld = !m_valid || bus.i_ready;
    er = (ld && g >= 0) ? C'(1 << g) : '0;
    chk({tag, ".ready"}, 32'(bus.o_ready), 32'(er));
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(m_valid));
    chk({tag, ".data"}, 32'(bus.o_data), 32'(m_data));
    chk({tag, ".sel"}, 32'(bus.o_sel), 32'(m_sel));
    @(posedge i_clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.i_data[g*W +: W];
        m_sel   = g;
`ifdef WORD_ARBMUX_RR_EN
        m_ptr   = (g + 1) % C;
`endif
      end else m_valid = 1'b0;
    end
    #1;
  endtask
  initial begin
    int exp_sel;
    bus.i_valid = C'($urandom);
    bus.i_data  = {$urandom, $urandom};
    bus.i_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst.valid", 32'(bus.o_valid), 32'd0);
    chk("rst.data", 32'(bus.o_data), 32'h0000);
    chk("rst.sel", 32'(bus.o_sel), 32'd0);
    bus.i_valid = '0;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst.idle_ready", 32'(bus.o_ready), 32'd0);
    step("rst_idle");
    bus.i_valid = 4'b0100;
    bus.i_data[2*W +: W] = 16'hBEEF;
    #1;
    chk("single.ready", 32'(bus.o_ready), 32'b0100);
    step("single");
    chk("single.out_valid", 32'(bus.o_valid), 32'd1);
    chk("single.out_data", 32'(bus.o_data), 32'hBEEF);
    chk("single.out_sel", 32'(bus.o_sel), 32'd2);
    bus.i_valid = '0;
    step("single_drain");
    bus.i_valid = 4'b0001;
    bus.i_data[0 +: W] = 16'h1234;
    step("stall_load");
    bus.i_valid = 4'b1111;
    bus.i_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      chk("stall.ready", 32'(bus.o_ready), 32'd0);
      chk("stall.data", 32'(bus.o_data), 32'h1234);
    end
    bus.i_ready = 1'b1;
    #1;
    chk("stall.release_ready_nz", 32'(bus.o_ready != 0), 32'd1);
    step("stall_release");
`ifdef WORD_ARBMUX_RR_EN
    chk("stall.release_sel", 32'(bus.o_sel), 32'd1);
    chk("stall.release_data", 32'(bus.o_data), 32'h2222);
`else
    chk("stall.release_sel", 32'(bus.o_sel), 32'd0);
    chk("stall.release_data", 32'(bus.o_data), 32'h1111);
`endif
    bus.i_valid = 4'b1000;
    bus.i_data[3*W +: W] = 16'hAAAA;
    step("mid_load");
    chk("mid.held", 32'(bus.o_data), 32'hAAAA);
    bus.i_ready = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    bus.i_valid = '0;
    #1;
    chk("mid.rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid.rst_data", 32'(bus.o_data), 32'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_valid = 4'b1111;
    bus.i_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step("rr");
`ifdef WORD_ARBMUX_RR_EN
      exp_sel = i % C;
`else
      exp_sel = 0;
`endif
      chk("rr.sel", 32'(bus.o_sel), 32'(exp_sel));
      chk("rr.valid", 32'(bus.o_valid), 32'd1);
    end
    bus.i_valid = 4'b0100;
    step("wrap_prep");
    bus.i_valid = 4'b0011;
    step("wrap0");
    chk("wrap.first", 32'(bus.o_sel), 32'd0);
    step("wrap1");
`ifdef WORD_ARBMUX_RR_EN
    chk("wrap.second", 32'(bus.o_sel), 32'd1);
`else
    chk("wrap.second", 32'(bus.o_sel), 32'd0);
`endif
    for (int i = 0; i < 400; i++) begin
      bus.i_valid = C'($urandom);
      bus.i_data  = {$urandom, $urandom};
      bus.i_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
